mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the p4 MIPS core.
- Sequences a shared-memory datapath (PC, IR, GRF, ALU, EXT, unified memory) through FETCH/DECODE/EXE/MEM/WB and drives all datapath enables and muxes.
- Replaces the single-cycle combinational controller.
- Handles variable-latency memory through a req/ready handshake and keeps a retired-instruction counter for bench checking.

Parameters:
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk).
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0].
- alu_zero  in  1  ALU equality flag from the datapath.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe; qualified by mem_req.
- mem_sel  out  1  address select: 0 = PC (fetch), 1 = ALU result (data).
- ir_we  out  1  IR load enable.
- pc_we  out  1  PC write enable.
- pc_sel  out  2  next PC: 0 = PC+4, 1 = branch target, 2 = j/jal target, 3 = GRF[rs].
- rf_we  out  1  GRF write enable.
- rf_wa_sel  out  2  write address: 0 = rt, 1 = rd, 2 = $31.
- rf_wd_sel  out  2  write data: 0 = ALU, 1 = memory data register, 2 = PC (link).
- alu_src  out  1  0 = GRF[rt], 1 = extended immediate.
- ext_op  out  2  0 = zero extend, 1 = sign extend, 2 = lui shift.
- alu_op  out  3  0 = add, 1 = sub, 2 = or.
- state  out  3  current state (debug).
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- States: FETCH = 0, DECODE = 1, EXE = 2, MEM = 3, WB = 4. Outputs are Moore-style decodes of state plus opcode/funct.
- Reset:
  - While reset = 0 at an edge: state <= FETCH, retired <= 0.
  - While reset is low, every output strobe (mem_req, mem_we, ir_we, pc_we, rf_we) is forced 0; mux selects are 0.
  - Reset mid-instruction abandons it. Any outstanding mem_req drops the same cycle and no PC/GRF write occurs.
- FETCH:
  - Outputs: mem_req = 1, mem_sel = 0.
  - Waits while mem_ready = 0, with all write enables 0.
  - On mem_ready = 1: ir_we = 1, pc_we = 1, pc_sel = 0, then go to DECODE.
- DECODE (PC already holds old PC+4):
  - j: pc_we = 1, pc_sel = 2, then FETCH.
  - jal: same as j, plus rf_we = 1, rf_wa_sel = 2, rf_wd_sel = 2, in the same cycle, then FETCH.
  - jr (opcode 0, funct 0x08): pc_we = 1, pc_sel = 3, then FETCH.
  - addu/subu/ori/lui/lw/sw/beq: go to EXE.
  - Any other encoding: treated as nop, then FETCH.
- EXE:
  - addu (funct 0x21): alu_op = 0, alu_src = 0. subu (funct 0x23): alu_op = 1, alu_src = 0. Both go to WB.
  - ori: alu_op = 2, alu_src = 1, ext_op = 0, then WB.
  - lui: alu_op = 2 ($0 | imm<<16), alu_src = 1, ext_op = 2, then WB.
  - lw/sw: alu_op = 0, alu_src = 1, ext_op = 1, then MEM.
  - beq: alu_op = 1, ext_op = 1, pc_sel = 1, pc_we = alu_zero, then FETCH.
- MEM:
  - Outputs: mem_req = 1, mem_sel = 1, mem_we = 1 for sw only.
  - Holds until mem_ready = 1.
  - Then: sw goes to FETCH; lw goes to WB (memory data register captured by the datapath on that edge).
- WB:
  - rf_we = 1, then FETCH.
  - Write address: rd for addu/subu; rt for ori/lui/lw.
  - Write data: rf_wd_sel = 1 for lw, else 0.
- Instruction latency (cycles, mem_ready always 1): j/jal/jr/nop 2, beq 3, R-type/ori/lui/sw 4, lw 5. Each wait cycle adds 1.
- Retired counter:
  - retired increments by 1 on every transition into FETCH from a state other than FETCH.
  - Wraps modulo 2^CNT_W.
- mem_ready outside FETCH/MEM is ignored.
- mem_we is never 1 unless mem_req = 1.

Decomposition:
- Package mc_pkg holds:
  - state encodings;
  - opcode/funct constants (OP_RTYPE 0x00, OP_ORI 0x0D, OP_LUI 0x0F, OP_LW 0x23, OP_SW 0x2B, OP_BEQ 0x04, OP_J 0x02, OP_JAL 0x03, FN_ADDU, FN_SUBU, FN_JR);
  - the pc_sel, rf_wa_sel, rf_wd_sel, ext_op and alu_op codes.
- One sub-module, mc_decode: pure combinational instruction classifier (opcode, funct to class one-hot). The FSM and output logic stay in mc_ctrl.

Test Plan:
- Reset: hold reset = 0 for 2 edges with mem_ready = 1 -> state = 0, retired = 0, all strobes 0. Release -> mem_req = 1 on the first cycle.
- addu (op 0x00, fn 0x21), mem_ready = 1 -> states 0,1,2,4. rf_we = 1 only in WB with rf_wa_sel = 1. retired = 1 after 4 cycles.
- lw with mem_ready low 3 cycles in MEM -> MEM held 4 cycles, no rf_we until WB, rf_wd_sel = 1. Total 8 cycles.
- beq with alu_zero = 1, then alu_zero = 0 -> pc_we = 1 with pc_sel = 1 in EXE for the first case only. Both take 3 cycles.
- jal -> in DECODE, pc_we = 1, pc_sel = 2, rf_we = 1, rf_wa_sel = 2, rf_wd_sel = 2 simultaneously. Back to FETCH after 2 cycles.
- Reset asserted during MEM of sw with mem_ready = 0 -> next edge state = FETCH, mem_we = 0, retired = 0. No PC write.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes,
// functs, datapath mux codes and the instruction class vector.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_BR    = 2'd1;
  localparam logic [1:0] PC_JUMP  = 2'd2;
  localparam logic [1:0] PC_REG   = 2'd3;

  localparam logic [1:0] WA_RT    = 2'd0;
  localparam logic [1:0] WA_RD    = 2'd1;
  localparam logic [1:0] WA_RA    = 2'd2;

  localparam logic [1:0] WD_ALU   = 2'd0;
  localparam logic [1:0] WD_MEM   = 2'd1;
  localparam logic [1:0] WD_PC    = 2'd2;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;

  // Exactly one field is set for any encoding; unknown encodings land in nop.
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic nop;
  } icls_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to one-hot class.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output icls_t      cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls.addu = 1'b1;
          FN_SUBU: cls.subu = 1'b1;
          FN_JR:   cls.jr   = 1'b1;
          default: cls.nop  = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: cls.nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the p4 MIPS core: FETCH/DECODE/EXE/MEM/WB
// sequencing, datapath enables and mux selects, retired-instruction counter.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       rf_wa_sel,
  output logic [1:0]       rf_wd_sel,
  output logic             alu_src,
  output logic [1:0]       ext_op,
  output logic [2:0]       alu_op,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t state_q;
  icls_t  cls;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls)
  );

  assign state = state_q;

  // Every return to FETCH from another state marks a completed instruction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      retired <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_ready) state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (cls.j || cls.jal || cls.jr || cls.nop) begin
            state_q <= S_FETCH;
            retired <= retired + CNT_W'(1);
          end else begin
            state_q <= S_EXE;
          end
        end
        S_EXE: begin
          if (cls.lw || cls.sw) begin
            state_q <= S_MEM;
          end else if (cls.beq) begin
            state_q <= S_FETCH;
            retired <= retired + CNT_W'(1);
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (cls.lw) begin
              state_q <= S_WB;
            end else begin
              state_q <= S_FETCH;
              retired <= retired + CNT_W'(1);
            end
          end
        end
        S_WB: begin
          state_q <= S_FETCH;
          retired <= retired + CNT_W'(1);
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Outputs decode combinationally so a reset drops requests in the same cycle.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    rf_we     = 1'b0;
    rf_wa_sel = WA_RT;
    rf_wd_sel = WD_ALU;
    alu_src   = 1'b0;
    ext_op    = EXT_ZERO;
    alu_op    = ALU_ADD;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
          end
        end
        S_DECODE: begin
          if (cls.j || cls.jal) begin
            pc_we  = 1'b1;
            pc_sel = PC_JUMP;
          end
          if (cls.jal) begin
            rf_we     = 1'b1;
            rf_wa_sel = WA_RA;
            rf_wd_sel = WD_PC;
          end
          if (cls.jr) begin
            pc_we  = 1'b1;
            pc_sel = PC_REG;
          end
        end
        S_EXE: begin
          if (cls.subu || cls.beq)     alu_op = ALU_SUB;
          else if (cls.ori || cls.lui) alu_op = ALU_OR;
          alu_src = cls.ori || cls.lui || cls.lw || cls.sw;
          if (cls.lui)                            ext_op = EXT_LUI;
          else if (cls.lw || cls.sw || cls.beq)   ext_op = EXT_SIGN;
          if (cls.beq) begin
            pc_sel = PC_BR;
            pc_we  = alu_zero;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_sel = 1'b1;
          mem_we  = cls.sw;
        end
        S_WB: begin
          rf_we     = 1'b1;
          rf_wa_sel = (cls.addu || cls.subu) ? WA_RD : WA_RT;
          rf_wd_sel = cls.lw ? WD_MEM : WD_ALU;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: each instruction is described by the states it
// visits and the writes it makes; per-cycle outputs are checked against that.
module tb_mc_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode, funct;
  logic          alu_zero, mem_ready;
  logic          mem_req, mem_we, mem_sel, ir_we, pc_we, rf_we, alu_src;
  logic [1:0]    pc_sel, rf_wa_sel, rf_wd_sel, ext_op;
  logic [2:0]    alu_op, state;
  logic [CW-1:0] retired;

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_sel(mem_sel), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .rf_we(rf_we), .rf_wa_sel(rf_wa_sel),
    .rf_wd_sel(rf_wd_sel), .alu_src(alu_src), .ext_op(ext_op),
    .alu_op(alu_op), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Instruction description: visited states (bit per state), when PC / GRF are
  // written and with which source, and the ALU setup expected during EXE.
  typedef struct {
    bit [4:0] visits;
    int       pc_ph;  int pc_src; bit pc_cond;
    int       rf_ph;  int wa;     int wd;
    int       aop;    int asrc;   bit chk_asrc;
    int       eop;    bit chk_eop;
    bit       sw;
  } desc_t;

  localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LUI = 4, K_LW = 5,
                 K_SW = 6, K_BEQ = 7, K_J = 8, K_JAL = 9, K_NOP = 10;

  function automatic desc_t describe(input int k);
    desc_t d;
    d.visits = 5'b00011; d.pc_ph = -1; d.pc_src = 0; d.pc_cond = 0;
    d.rf_ph = -1; d.wa = 0; d.wd = 0; d.aop = 0; d.asrc = 0; d.chk_asrc = 0;
    d.eop = 0; d.chk_eop = 0; d.sw = 0;
    case (k)
      K_ADDU, K_SUBU: begin
        d.visits = 5'b10111; d.rf_ph = 4; d.wa = 1; d.wd = 0;
        d.aop = (k == K_SUBU) ? 1 : 0; d.asrc = 0; d.chk_asrc = 1;
      end
      K_ORI, K_LUI: begin
        d.visits = 5'b10111; d.rf_ph = 4; d.wa = 0; d.wd = 0;
        d.aop = 2; d.asrc = 1; d.chk_asrc = 1;
        d.eop = (k == K_LUI) ? 2 : 0; d.chk_eop = 1;
      end
      K_LW: begin
        d.visits = 5'b11111; d.rf_ph = 4; d.wa = 0; d.wd = 1;
        d.aop = 0; d.asrc = 1; d.chk_asrc = 1; d.eop = 1; d.chk_eop = 1;
      end
      K_SW: begin
        d.visits = 5'b01111; d.sw = 1;
        d.aop = 0; d.asrc = 1; d.chk_asrc = 1; d.eop = 1; d.chk_eop = 1;
      end
      K_BEQ: begin
        d.visits = 5'b00111; d.pc_ph = 2; d.pc_src = 1; d.pc_cond = 1;
        d.aop = 1; d.eop = 1; d.chk_eop = 1;
      end
      K_J:   begin d.pc_ph = 1; d.pc_src = 2; end
      K_JAL: begin d.pc_ph = 1; d.pc_src = 2; d.rf_ph = 1; d.wa = 2; d.wd = 2; end
      K_JR:  begin d.pc_ph = 1; d.pc_src = 3; end
      default: ;
    endcase
    return d;
  endfunction

  desc_t      d;
  int         p;          // state the model says the DUT is in
  int         ret_m;
  logic [5:0] cur_op, cur_fn;

  function automatic bit is_legal_op(input logic [5:0] o);
    return o inside {6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
  endfunction

  task automatic pick_instr();
    int k;
    logic [5:0] o, f;
    k = $urandom_range(0, 10);
    f = 6'($urandom_range(0, 63));
    case (k)
      K_ADDU: begin o = 6'h00; f = 6'h21; end
      K_SUBU: begin o = 6'h00; f = 6'h23; end
      K_JR:   begin o = 6'h00; f = 6'h08; end
      K_ORI:  o = 6'h0D;
      K_LUI:  o = 6'h0F;
      K_LW:   o = 6'h23;
      K_SW:   o = 6'h2B;
      K_BEQ:  o = 6'h04;
      K_J:    o = 6'h02;
      K_JAL:  o = 6'h03;
      default: begin
        if ($urandom_range(0, 1) == 0) begin
          o = 6'h00;
          while (f == 6'h21 || f == 6'h23 || f == 6'h08) f = 6'($urandom_range(0, 63));
        end else begin
          o = 6'h00;
          while (is_legal_op(o)) o = 6'($urandom_range(0, 63));
        end
      end
    endcase
    cur_op = o; cur_fn = f; d = describe(k); p = 0;
  endtask

  logic [7:0]  act_st, exp_st;
  logic [12:0] act_sel, exp_sel, msk_sel;
  bit          rst_v, mr_v, az_v;

  task automatic build_expect();
    bit req, we, irw, pcw, rfw, pc_chk;
    exp_sel = '0; msk_sel = '0;
    if (!rst_v) begin
      exp_st  = {3'(p), 5'b0};
      msk_sel = '1;
      return;
    end
    req    = (p == 0 || p == 3);
    we     = (p == 3) && d.sw;
    irw    = (p == 0) && mr_v;
    pcw    = ((p == 0) && mr_v) || ((p == d.pc_ph) && (!d.pc_cond || az_v));
    rfw    = (p == d.rf_ph);
    exp_st = {3'(p), req, we, irw, pcw, rfw};
    if (req) begin msk_sel[12] = 1; exp_sel[12] = (p == 3); end
    pc_chk = ((p == 0) && mr_v) || (p == d.pc_ph);
    if (pc_chk) begin msk_sel[11:10] = '1; exp_sel[11:10] = (p == 0) ? 2'd0 : 2'(d.pc_src); end
    if (rfw) begin
      msk_sel[9:6] = '1; exp_sel[9:8] = 2'(d.wa); exp_sel[7:6] = 2'(d.wd);
    end
    if (p == 2) begin
      msk_sel[2:0] = '1; exp_sel[2:0] = 3'(d.aop);
      if (d.chk_asrc) begin msk_sel[5] = 1; exp_sel[5] = 1'(d.asrc); end
      if (d.chk_eop)  begin msk_sel[4:3] = '1; exp_sel[4:3] = 2'(d.eop); end
    end
  endtask

  task automatic advance();
    int nxt;
    if (!rst_v) begin
      ret_m = 0;
      pick_instr();
      return;
    end
    if ((p == 0 || p == 3) && !mr_v) return;
    nxt = -1;
    for (int s = 4; s > p; s--) if (d.visits[s]) nxt = s;
    if (nxt < 0) begin
      ret_m = (ret_m + 1) % (1 << CW);
      pick_instr();
    end else begin
      p = nxt;
    end
  endtask

  initial begin
    reset = 1'b0; mem_ready = 1'b1; alu_zero = 1'b0; opcode = '0; funct = '0;
    @(posedge clk); @(posedge clk); #1;
    act_st = {state, mem_req, mem_we, ir_we, pc_we, rf_we};
    chk("reset_state_strobes", 32'(act_st), 32'h0);
    chk("reset_retired", 32'(retired), 32'h0);
    ret_m = 0;
    pick_instr();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst_v = ($urandom_range(0, 39) != 0);
      mr_v  = ($urandom_range(0, 9) < 7);
      az_v  = 1'($urandom_range(0, 1));
      reset = rst_v; mem_ready = mr_v; alu_zero = az_v;
      if (p == 0) begin
        opcode = 6'($urandom_range(0, 63)); funct = 6'($urandom_range(0, 63));
      end else begin
        opcode = cur_op; funct = cur_fn;
      end
      @(negedge clk);
      build_expect();
      act_st  = {state, mem_req, mem_we, ir_we, pc_we, rf_we};
      act_sel = {mem_sel, pc_sel, rf_wa_sel, rf_wd_sel, alu_src, ext_op, alu_op};
      chk("state_strobes", 32'(act_st), 32'(exp_st));
      chk("mux_selects", 32'(act_sel & msk_sel), 32'(exp_sel));
      chk("retired", 32'(retired), 32'(ret_m));
      @(posedge clk); #1;
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
